// File: rtl/seq_mult_16_pkg.sv
// Shared state encodings and iteration constants for the 16x16 shift-add multiplier.
package seq_mult_16_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         ITER      = 16;
    localparam logic [4:0] LAST_STEP = 5'(ITER - 1);

endpackage

// File: rtl/adder_16.sv
// 16-bit ripple adder with carry in/out, used by the shift-add multiplier datapath.
module adder_16 (
    input  logic        clk,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        c
);

    assign {c, s} = {1'b0, a} + {1'b0, b} + {16'd0, cin};

    // The sum is combinational; clk only times this X-propagation check.
    a_no_x_out: assert property (@(posedge clk) !$isunknown({a, b, cin}) |-> !$isunknown({c, s}));

endmodule

// File: rtl/seq_mult_16.sv
// Unsigned 16x16 sequential multiplier: one shift-add step per cycle, fixed 17-cycle latency.
module seq_mult_16
    import seq_mult_16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] p
);

    state_t      state, state_next;
    logic [15:0] mcand;
    logic [31:0] acc;
    logic [31:0] acc_shift;
    logic [4:0]  count;
    logic [15:0] addend;
    logic [15:0] sum;
    logic        carry;
    logic        accept;
    logic        step;
    logic        finish;

    assign addend = acc[0] ? mcand : 16'd0;

    adder_16 u_adder (
        .clk (clk),
        .a   (acc[31:16]),
        .b   (addend),
        .cin (1'b0),
        .s   (sum),
        .c   (carry)
    );

    // Carry lands in bit 31 so the full 32-bit product survives the shift.
    assign acc_shift = {carry, sum, acc[15:1]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a missed branch would otherwise infer a latch.
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (count == LAST_STEP) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register here sees pre-edge values of the others.
        if (rst) begin
            mcand <= '0;
            acc   <= '0;
            count <= '0;
            p     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            busy <= (state_next == CALC);
            done <= (state_next == DONE);
            if (accept) begin
                mcand <= a;
                acc   <= {16'd0, b};
                count <= '0;
            end else if (step) begin
                acc   <= acc_shift;
                count <= count + 5'd1;
            end
            // Product is latched on entry to DONE so it is valid in the done cycle itself.
            if (finish) p <= acc_shift;
        end
    end

endmodule

// File: tb/tb_seq_mult_16.sv
// Directed self-checking bench for seq_mult_16 with a product scoreboard checked on every done pulse.
module tb_seq_mult_16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] p;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_p;

    seq_mult_16 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Every done pulse must match the oldest outstanding product; a done with nothing pending is an error.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_p = sb.pop_front();
                check("product", p, exp_p);
            end
        end
    end

    // Launch one multiply, optionally re-pulsing start at cycle poke_at with a=2, b=2.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input int poke_at);
        int          cyc;
        int          busy_cyc;
        logic [31:0] p_before;
        @(negedge clk);
        p_before = p;
        start = 1'b1;
        a     = ta;
        b     = tb;
        sb.push_back({16'd0, ta} * {16'd0, tb});
        @(negedge clk);
        start    = 1'b0;
        cyc      = 1;
        busy_cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) busy_cyc++;
            if (cyc == poke_at) begin
                start = 1'b1;
                a     = 16'h0002;
                b     = 16'h0002;
                check("p_hold_in_calc", p, p_before);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("latency", 32'(cyc), 32'd17);
        check("busy_cycles", 32'(busy_cyc), 32'd16);
        check("busy_at_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        a     = 16'h0005;
        b     = 16'h0007;
        repeat (3) @(negedge clk);
        check("rst_over_start_busy", 32'(busy), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        check("reset_done", 32'(done), 32'd0);
        check("reset_p", p, 32'd0);

        run_op(16'h0003, 16'h0005, 0);
        repeat (3) @(negedge clk);
        check("p_idle_hold_0f", p, 32'h0000000F);

        run_op(16'h1234, 16'h0000, 0);
        run_op(16'h0000, 16'h1234, 0);
        run_op(16'hFFFF, 16'hFFFF, 0);

        run_op(16'h0007, 16'h0009, 5);
        repeat (20) @(negedge clk);
        check("p_after_ignored_start", p, 32'h0000003F);
        check("idle_busy_after_ignore", 32'(busy), 32'd0);

        // Abort 0x00FF*0x0101 with reset in cycle 8; no product is expected from it.
        @(negedge clk);
        start = 1'b1;
        a     = 16'h00FF;
        b     = 16'h0101;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_p", p, 32'd0);
        repeat (20) @(negedge clk);
        check("abort_quiet_busy", 32'(busy), 32'd0);

        run_op(16'h0010, 16'h0010, 0);
        run_op(16'h8000, 16'h0002, 0);
        repeat (2) @(negedge clk);
        check("final_p_hold", p, 32'h00010000);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
